ili9341_parallel_8bit_rx: RTL

ILI9341_PARALLEL_8BIT_RX -- requirements
Module: ili9341_parallel_8bit_rx

---
 rtl/ili9341_pkg.sv | 27 ++
 rtl/ili9341_bus_sync.sv | 66 ++++++
 rtl/ili9341_parallel_8bit_rx.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ili9341_pkg.sv
// Shared definitions for the ILI9341 8-bit parallel write receiver:
// command codes, FSM states and the RGB565 pixel type.
package ili9341_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;
    localparam logic [7:0] CMD_RAMWRC  = 8'h3C;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PARAM = 2'd1,
        S_PIXHI = 2'd2,
        S_PIXLO = 2'd3
    } state_e;

    typedef logic [15:0] rgb565_t;

    // A window is usable only if start <= end and end lies inside the panel.
    function automatic logic window_ok(input logic [15:0] start_v,
                                       input logic [15:0] end_v,
                                       input logic [15:0] limit);
        return (start_v <= end_v) && (end_v < limit);
    endfunction

endpackage

// File: rtl/ili9341_bus_sync.sv
// Brings the asynchronous 8080-style bus into the clk domain and turns the
// synchronized lcd_wr rising edge (with cs low) into a single-cycle strobe.
module ili9341_bus_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_rst,
    input  logic       lcd_cs,
    input  logic       lcd_rs,
    input  logic       lcd_wr,
    input  logic [7:0] lcd_d,
    output logic       wr_stb,
    output logic       bus_rs,
    output logic [7:0] bus_d,
    output logic       cs_rise,
    output logic       panel_rst
);

    logic       cs_m, cs_s, cs_p;
    logic       wr_m, wr_s, wr_p;
    logic       rs_m, rs_s, rs_p;
    logic [7:0] d_m, d_s, d_p;
    logic       rst_m, rst_s;

    // Idle bus levels at reset so no spurious edge is seen on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_m  <= 1'b1;
            cs_s  <= 1'b1;
            cs_p  <= 1'b1;
            wr_m  <= 1'b1;
            wr_s  <= 1'b1;
            wr_p  <= 1'b1;
            rs_m  <= 1'b0;
            rs_s  <= 1'b0;
            rs_p  <= 1'b0;
            d_m   <= 8'h00;
            d_s   <= 8'h00;
            d_p   <= 8'h00;
            rst_m <= 1'b1;
            rst_s <= 1'b1;
        end else begin
            cs_m  <= lcd_cs;
            cs_s  <= cs_m;
            cs_p  <= cs_s;
            wr_m  <= lcd_wr;
            wr_s  <= wr_m;
            wr_p  <= wr_s;
            rs_m  <= lcd_rs;
            rs_s  <= rs_m;
            rs_p  <= rs_s;
            d_m   <= lcd_d;
            d_s   <= d_m;
            d_p   <= d_s;
            rst_m <= lcd_rst;
            rst_s <= rst_m;
        end
    end

    // rs/d are taken one cycle behind, i.e. the values held before wr rose.
    assign wr_stb    = wr_s & ~wr_p & ~cs_s;
    assign bus_rs    = rs_p;
    assign bus_d     = d_p;
    assign cs_rise   = cs_s & ~cs_p;
    assign panel_rst = ~rst_s;

endmodule

// File: rtl/ili9341_parallel_8bit_rx.sv
// ILI9341 8-bit parallel write receiver: decodes commands, CASET/PASET
// windows and RAMWR/RAMWRC pixel streams into cmd and pixel pulses.
module ili9341_parallel_8bit_rx
    import ili9341_pkg::*;
#(
    parameter int H_RES = 240,
    parameter int V_RES = 320
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_rst,
    input  logic       lcd_cs,
    input  logic       lcd_rs,
    input  logic       lcd_wr,
    input  logic       lcd_rd,
    input  logic [7:0] lcd_d,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic       pix_valid,
    output logic [8:0] pix_x,
    output logic [8:0] pix_y,
    output rgb565_t    pix_data,
    output logic       proto_err,
    output logic [1:0] dbg_state
);

    localparam logic [8:0]  EC_DEF = 9'(H_RES - 1);
    localparam logic [8:0]  EP_DEF = 9'(V_RES - 1);
    localparam logic [15:0] H_LIM  = 16'(H_RES);
    localparam logic [15:0] V_LIM  = 16'(V_RES);

    logic       wr_stb, bus_rs, cs_rise, panel_rst;
    logic [7:0] bus_d;
    logic       unused_rd;

    assign unused_rd = lcd_rd;

    ili9341_bus_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .lcd_rst   (lcd_rst),
        .lcd_cs    (lcd_cs),
        .lcd_rs    (lcd_rs),
        .lcd_wr    (lcd_wr),
        .lcd_d     (lcd_d),
        .wr_stb    (wr_stb),
        .bus_rs    (bus_rs),
        .bus_d     (bus_d),
        .cs_rise   (cs_rise),
        .panel_rst (panel_rst)
    );

    state_e      state, state_n;
    logic [1:0]  pcnt, pcnt_n;
    logic        ppage, ppage_n;
    logic [23:0] pbuf, pbuf_n;
    logic [8:0]  sc, sc_n, ec, ec_n, sp, sp_n, ep, ep_n;
    logic [8:0]  cx, cx_n, cy, cy_n;
    logic [7:0]  hi, hi_n;
    logic        cmd_valid_n, pix_valid_n, proto_err_n;
    logic [7:0]  cmd_code_n;
    logic [8:0]  pix_x_n, pix_y_n;
    rgb565_t     pix_data_n;

    logic [15:0] p_start, p_end;
    logic        p_ok;

    // Fourth parameter byte is still on the bus; the first three sit in pbuf.
    assign p_start   = pbuf[23:8];
    assign p_end     = {pbuf[7:0], bus_d};
    assign p_ok      = window_ok(p_start, p_end, ppage ? V_LIM : H_LIM);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pcnt      <= 2'd0;
            ppage     <= 1'b0;
            pbuf      <= 24'h0;
            sc        <= 9'd0;
            ec        <= EC_DEF;
            sp        <= 9'd0;
            ep        <= EP_DEF;
            cx        <= 9'd0;
            cy        <= 9'd0;
            hi        <= 8'h00;
            cmd_valid <= 1'b0;
            cmd_code  <= 8'h00;
            pix_valid <= 1'b0;
            pix_x     <= 9'd0;
            pix_y     <= 9'd0;
            pix_data  <= 16'h0000;
            proto_err <= 1'b0;
        end else begin
            state     <= state_n;
            pcnt      <= pcnt_n;
            ppage     <= ppage_n;
            pbuf      <= pbuf_n;
            sc        <= sc_n;
            ec        <= ec_n;
            sp        <= sp_n;
            ep        <= ep_n;
            cx        <= cx_n;
            cy        <= cy_n;
            hi        <= hi_n;
            cmd_valid <= cmd_valid_n;
            cmd_code  <= cmd_code_n;
            pix_valid <= pix_valid_n;
            pix_x     <= pix_x_n;
            pix_y     <= pix_y_n;
            pix_data  <= pix_data_n;
            proto_err <= proto_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        pcnt_n      = pcnt;
        ppage_n     = ppage;
        pbuf_n      = pbuf;
        sc_n        = sc;
        ec_n        = ec;
        sp_n        = sp;
        ep_n        = ep;
        cx_n        = cx;
        cy_n        = cy;
        hi_n        = hi;
        cmd_valid_n = 1'b0;
        cmd_code_n  = cmd_code;
        pix_valid_n = 1'b0;
        pix_x_n     = pix_x;
        pix_y_n     = pix_y;
        pix_data_n  = pix_data;
        proto_err_n = proto_err;

        if (panel_rst) begin
            // Panel hardware reset mirrors rst_n, but synchronously.
            state_n     = S_IDLE;
            pcnt_n      = 2'd0;
            ppage_n     = 1'b0;
            pbuf_n      = 24'h0;
            sc_n        = 9'd0;
            ec_n        = EC_DEF;
            sp_n        = 9'd0;
            ep_n        = EP_DEF;
            cx_n        = 9'd0;
            cy_n        = 9'd0;
            hi_n        = 8'h00;
            cmd_code_n  = 8'h00;
            pix_x_n     = 9'd0;
            pix_y_n     = 9'd0;
            pix_data_n  = 16'h0000;
            proto_err_n = 1'b0;
        end else if (wr_stb && !bus_rs) begin
            cmd_valid_n = 1'b1;
            cmd_code_n  = bus_d;
            pcnt_n      = 2'd0;
            state_n     = S_IDLE;
            case (bus_d)
                CMD_CASET: begin
                    state_n = S_PARAM;
                    ppage_n = 1'b0;
                end
                CMD_PASET: begin
                    state_n = S_PARAM;
                    ppage_n = 1'b1;
                end
                CMD_RAMWR: begin
                    state_n = S_PIXHI;
                    cx_n    = sc;
                    cy_n    = sp;
                end
                CMD_RAMWRC: state_n = S_PIXHI;
                CMD_SWRESET: begin
                    sc_n        = 9'd0;
                    ec_n        = EC_DEF;
                    sp_n        = 9'd0;
                    ep_n        = EP_DEF;
                    cx_n        = 9'd0;
                    cy_n        = 9'd0;
                    proto_err_n = 1'b0;
                end
                default: ;
            endcase
        end else if (wr_stb) begin
            case (state)
                S_PARAM: begin
                    if (pcnt == 2'd3) begin
                        state_n = S_IDLE;
                        pcnt_n  = 2'd0;
                        if (!p_ok) begin
                            proto_err_n = 1'b1;
                        end else if (ppage) begin
                            sp_n = p_start[8:0];
                            ep_n = p_end[8:0];
                        end else begin
                            sc_n = p_start[8:0];
                            ec_n = p_end[8:0];
                        end
                    end else begin
                        pbuf_n = {pbuf[15:0], bus_d};
                        pcnt_n = pcnt + 2'd1;
                    end
                end
                S_PIXHI: begin
                    hi_n    = bus_d;
                    state_n = S_PIXLO;
                end
                S_PIXLO: begin
                    pix_valid_n = 1'b1;
                    pix_x_n     = cx;
                    pix_y_n     = cy;
                    pix_data_n  = {hi, bus_d};
                    state_n     = S_PIXHI;
                    if (cx == ec) begin
                        cx_n = sc;
                        cy_n = (cy == ep) ? sp : cy + 9'd1;
                    end else begin
                        cx_n = cx + 9'd1;
                    end
                end
                default: ;
            endcase
        end else if (cs_rise) begin
            // Deselect drops any half-received parameter or pixel.
            if (state == S_PARAM) begin
                state_n = S_IDLE;
                pcnt_n  = 2'd0;
            end else if (state == S_PIXLO) begin
                state_n = S_PIXHI;
            end
        end
    end

endmodule
